// File: rtl/alu_operand_ctrl.sv
// Operand registers and sequencing for an external adder/subtractor whose result is ready ALU_LAT cycles
// after the operands. Defining ALU_FLAGS_EN adds zero_o/neg_o flags taken from the captured result.
module alu_operand_ctrl #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] bus_i,
  input  logic       load_a_i,
  input  logic       load_b_i,
  input  logic       start_i,
  input  logic       sub_i,
  input  logic [7:0] alu_res_i,
  output logic [7:0] a_o,
  output logic [7:0] b_o,
  output logic       sub_en_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] result_o,
`ifdef ALU_FLAGS_EN
  output logic       zero_o,
  output logic       neg_o,
`endif
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  state_e     state_q;
  logic [7:0] a_q, b_q, result_q;
  logic       sub_q, busy_q, done_q;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
`ifdef ALU_FLAGS_EN
  logic       zero_q, neg_q;
`endif

  assign cnt_d = cnt_q + 3'd1;

  // Handshake: start_i is a request with no backpressure. It is taken only while busy_o=0;
  // a request (or load) arriving while busy_o=1 is dropped, never queued. done_o pulses once
  // per accepted request, in the cycle after the result is captured.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      result_q <= 8'h00;
      sub_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= 3'd0;
`ifdef ALU_FLAGS_EN
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_a_i) a_q <= bus_i;
          if (load_b_i) b_q <= bus_i;
          if (start_i) begin
            sub_q   <= sub_i;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_d == 3'(ALU_LAT)) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // Result is written back into A so consecutive operations accumulate.
          result_q <= alu_res_i;
          a_q      <= alu_res_i;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
`ifdef ALU_FLAGS_EN
          zero_q   <= (alu_res_i == 8'h00);
          neg_q    <= alu_res_i[7];
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a_o      = a_q;
  assign b_o      = b_q;
  assign sub_en_o = sub_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign state_o  = state_q;
`ifdef ALU_FLAGS_EN
  assign zero_o   = zero_q;
  assign neg_o    = neg_q;
`endif

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Bench for alu_operand_ctrl: one instance at ALU_LAT=1 with random and directed traffic,
// one at ALU_LAT=4 for latency timing. Each instance is fed by a simple pipelined ALU.
module tb_alu_operand_ctrl;
  localparam int LAT1 = 1;
  localparam int LAT4 = 4;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [7:0] bus_i = 8'h00, alu_res_i;
  logic       load_a_i = 0, load_b_i = 0, start_i = 0, sub_i = 0;
  logic [7:0] a_o, b_o, result_o;
  logic       sub_en_o, busy_o, done_o;
  logic [1:0] state_o;

  logic [7:0] bus_4 = 8'h00, alu_res_4;
  logic       load_a_4 = 0, load_b_4 = 0, start_4 = 0, sub_4 = 0;
  logic [7:0] a_4, b_4, result_4;
  logic       sub_en_4, busy_4, done_4;
  logic [1:0] state_4;
`ifdef ALU_FLAGS_EN
  logic zero_o, neg_o, zero_4, neg_4;
`endif

  alu_operand_ctrl #(.ALU_LAT(LAT1)) u_dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .bus_i(bus_i), .load_a_i(load_a_i), .load_b_i(load_b_i),
    .start_i(start_i), .sub_i(sub_i), .alu_res_i(alu_res_i), .a_o(a_o), .b_o(b_o),
    .sub_en_o(sub_en_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
`ifdef ALU_FLAGS_EN
    .zero_o(zero_o), .neg_o(neg_o),
`endif
    .state_o(state_o)
  );

  alu_operand_ctrl #(.ALU_LAT(LAT4)) u_dut4 (
    .clk_i(clk_i), .rstn_i(rstn_i), .bus_i(bus_4), .load_a_i(load_a_4), .load_b_i(load_b_4),
    .start_i(start_4), .sub_i(sub_4), .alu_res_i(alu_res_4), .a_o(a_4), .b_o(b_4),
    .sub_en_o(sub_en_4), .busy_o(busy_4), .done_o(done_4), .result_o(result_4),
`ifdef ALU_FLAGS_EN
    .zero_o(zero_4), .neg_o(neg_4),
`endif
    .state_o(state_4)
  );

  // Downstream adder/subtractor: combinational result followed by LAT register stages.
  logic [7:0] p1 [4];
  logic [7:0] p4 [4];
  always @(posedge clk_i) begin
    p1[0] <= sub_en_o ? a_o - b_o : a_o + b_o;
    for (int i = 1; i < 4; i++) p1[i] <= p1[i-1];
  end
  always @(posedge clk_i) begin
    p4[0] <= sub_en_4 ? a_4 - b_4 : a_4 + b_4;
    for (int j = 1; j < 4; j++) p4[j] <= p4[j-1];
  end
  assign alu_res_i = p1[LAT1-1];
  assign alu_res_4 = p4[LAT4-1];

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] mdl_a = 8'h00, mdl_b = 8'h00, mdl_res = 8'h00;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    load_a_i = 1'b0;
    load_b_i = 1'b0;
    start_i  = 1'b0;
    sub_i    = 1'b0;
    bus_i    = 8'($urandom);
  endtask

  task automatic load(input logic la, input logic lb, input logic [7:0] v);
    bus_i = v; load_a_i = la; load_b_i = lb; start_i = 1'b0;
    tick();
    if (la) mdl_a = v;
    if (lb) mdl_b = v;
    idle_inputs();
    n_tests++;
    if (a_o !== mdl_a || b_o !== mdl_b || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load: a=%h b=%h busy=%0b, expected a=%h b=%h busy=0", a_o, b_o, busy_o, mdl_a, mdl_b);
    end
  endtask

  // Starts one operation (optionally loading at the same edge) and follows it to the done cycle.
  task automatic run_op(input logic sub, input logic la, input logic lb, input logic [7:0] v,
                        input logic noise);
    logic [7:0] exp;
    bus_i = v; load_a_i = la; load_b_i = lb; sub_i = sub; start_i = 1'b1;
    if (la) mdl_a = v;
    if (lb) mdl_b = v;
    exp = sub ? 8'(mdl_a - mdl_b) : 8'(mdl_a + mdl_b);
    for (int c = 0; c <= LAT1; c++) begin
      tick();
      if (noise) begin
        load_a_i = 1'b1; load_b_i = 1'($urandom); bus_i = 8'hAA; start_i = 1'b1; sub_i = ~sub;
      end else begin
        idle_inputs();
      end
      n_tests++;
      if (busy_o !== 1'b1 || done_o !== 1'b0 || a_o !== mdl_a || b_o !== mdl_b || sub_en_o !== sub) begin
        n_fail++;
        $display("FAIL op_wait[%0d]: busy=%0b done=%0b a=%h b=%h sub=%0b, expected busy=1 done=0 a=%h b=%h sub=%0b",
                 c, busy_o, done_o, a_o, b_o, sub_en_o, mdl_a, mdl_b, sub);
      end
    end
    tick();
    idle_inputs();
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b1 || result_o !== exp || a_o !== exp || b_o !== mdl_b) begin
      n_fail++;
      $display("FAIL op_capture: busy=%0b done=%0b result=%h a=%h b=%h, expected busy=0 done=1 result=%h a=%h b=%h",
               busy_o, done_o, result_o, a_o, b_o, exp, exp, mdl_b);
    end
`ifdef ALU_FLAGS_EN
    n_tests++;
    if (zero_o !== (exp == 8'h00) || neg_o !== exp[7]) begin
      n_fail++;
      $display("FAIL op_flags: zero=%0b neg=%0b, expected zero=%0b neg=%0b", zero_o, neg_o, exp == 8'h00, exp[7]);
    end
`endif
    mdl_a   = exp;
    mdl_res = exp;
  endtask

  task automatic idle_check();
    tick();
    n_tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== mdl_res || a_o !== mdl_a || b_o !== mdl_b) begin
      n_fail++;
      $display("FAIL idle: done=%0b busy=%0b result=%h a=%h b=%h, expected done=0 busy=0 result=%h a=%h b=%h",
               done_o, busy_o, result_o, a_o, b_o, mdl_res, mdl_a, mdl_b);
    end
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if (a_o !== 8'h00 || b_o !== 8'h00 || result_o !== 8'h00 || sub_en_o !== 1'b0 ||
        busy_o !== 1'b0 || done_o !== 1'b0 || state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL %s: a=%h b=%h result=%h sub=%0b busy=%0b done=%0b state=%0d, expected all 0",
               name, a_o, b_o, result_o, sub_en_o, busy_o, done_o, state_o);
    end
`ifdef ALU_FLAGS_EN
    n_tests++;
    if (zero_o !== 1'b0 || neg_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_flags: zero=%0b neg=%0b, expected 0 0", name, zero_o, neg_o);
    end
`endif
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    tick();
    tick();
    check_zero("reset");
    #2 rstn_i = 1'b1;
  endtask

  task automatic test_add();
    load(1'b1, 1'b0, 8'h05);
    load(1'b0, 1'b1, 8'h03);
    run_op(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_check();
  endtask

  task automatic test_sub();
    load(1'b1, 1'b0, 8'h03);
    load(1'b0, 1'b1, 8'h05);
    run_op(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_check();
  endtask

  task automatic test_wrap_back_to_back();
    load(1'b1, 1'b0, 8'hFF);
    run_op(1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
    run_op(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_check();
  endtask

  task automatic test_ignore_busy();
    load(1'b1, 1'b1, 8'h20);
    load(1'b0, 1'b1, 8'h11);
    run_op(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    idle_check();
    idle_check();
  endtask

  task automatic test_reset_wait();
    load(1'b1, 1'b1, 8'h42);
    bus_i = 8'h00; start_i = 1'b1; sub_i = 1'b1;
    tick();
    idle_inputs();
    #2 rstn_i = 1'b0;
    #1 check_zero("reset_wait");
    mdl_a = 8'h00; mdl_b = 8'h00; mdl_res = 8'h00;
    tick();
    #2 rstn_i = 1'b1;
    for (int k = 0; k < 6; k++) idle_check();
  endtask

  task automatic test_lat4();
    bus_4 = 8'h10; load_a_4 = 1'b1;
    tick();
    bus_4 = 8'h07; load_a_4 = 1'b0; load_b_4 = 1'b1; start_4 = 1'b1; sub_4 = 1'b1;
    tick();
    load_b_4 = 1'b0; start_4 = 1'b0; sub_4 = 1'b0;
    for (int c = 0; c <= LAT4; c++) begin
      n_tests++;
      if (busy_4 !== 1'b1 || done_4 !== 1'b0) begin
        n_fail++;
        $display("FAIL lat4_wait[%0d]: busy=%0b done=%0b, expected busy=1 done=0", c, busy_4, done_4);
      end
      tick();
    end
    n_tests++;
    if (busy_4 !== 1'b0 || done_4 !== 1'b1 || result_4 !== 8'h09 || a_4 !== 8'h09) begin
      n_fail++;
      $display("FAIL lat4_capture: busy=%0b done=%0b result=%h a=%h, expected busy=0 done=1 result=09 a=09",
               busy_4, done_4, result_4, a_4);
    end
    tick();
    n_tests++;
    if (done_4 !== 1'b0) begin
      n_fail++;
      $display("FAIL lat4_pulse: done=%0b, expected 0", done_4);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 1)
        load(1'($urandom), 1'($urandom), 8'($urandom));
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) != 0) idle_check();
    end
    idle_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_wrap_back_to_back();
    test_ignore_busy();
    test_reset_wait();
    test_lat4();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
